// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline-control constants: stall masks, exception cause codes and
// the exception record captured when the MEM stage reports an event.
package pipe_ctrl_pkg;

    localparam logic        STOP       = 1'b1;
    localparam logic        NOSTOP     = 1'b0;
    localparam logic        RST_ENABLE = 1'b1;
    localparam logic [31:0] ZERO_WORD  = 32'h0000_0000;

    // Stall masks: bit0=PC, bit1=IF/ID, bit2=ID/EX, bit3=EX/MEM, bit4=MEM/WB, bit5=WB
    localparam logic [5:0] STALL_NONE = 6'b000000;
    localparam logic [5:0] STALL_IF   = 6'b000011;
    localparam logic [5:0] STALL_ID   = 6'b000111;
    localparam logic [5:0] STALL_EX   = 6'b001111;
    localparam logic [5:0] STALL_MEM  = 6'b011111;
    localparam logic [5:0] STALL_ALL  = 6'b111111;

    localparam logic [31:0] EXC_INT  = 32'h0000_0001;
    localparam logic [31:0] EXC_SYS  = 32'h0000_0008;
    localparam logic [31:0] EXC_RI   = 32'h0000_000a;
    localparam logic [31:0] EXC_OV   = 32'h0000_000c;
    localparam logic [31:0] EXC_TRAP = 32'h0000_000d;
    localparam logic [31:0] EXC_ERET = 32'h0000_000e;

    typedef struct packed {
        logic [31:0] code;
        logic [31:0] epc;
    } excp_t;

endpackage

// File: rtl/pipe_stall_enc.sv
// Priority encoder that turns the per-stage stall requests into a stall mask;
// the deepest requesting stage determines how much of the pipe freezes.
module pipe_stall_enc
    import pipe_ctrl_pkg::*;
(
    input  logic       req_if_i,
    input  logic       req_id_i,
    input  logic       req_ex_i,
    input  logic       req_mem_i,
    output logic [5:0] stall_o
);

    always_comb begin
        stall_o = STALL_NONE;
        if (req_mem_i)     stall_o = STALL_MEM;
        else if (req_ex_i) stall_o = STALL_EX;
        else if (req_id_i) stall_o = STALL_ID;
        else if (req_if_i) stall_o = STALL_IF;
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: merges stall requests, sequences exception/ERET redirection
// (freeze, drain in-flight fetch, one-cycle flush) and keeps stall perf/timeout counters.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR  = 32'h0000_0020,
    parameter int          TIMEOUT_CYC = 1024,
    parameter int          CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stallreq_if,
    input  logic             stallreq_id,
    input  logic             stallreq_ex,
    input  logic             stallreq_mem,
    input  logic             excp_valid,
    input  logic [31:0]      excp_type,
    input  logic [31:0]      cp0_epc,
    output logic [5:0]       stall,
    output logic             flush,
    output logic [31:0]      new_pc,
    output logic [CNT_W-1:0] stall_cycles,
    output logic             stall_timeout
);

    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {S_RUN, S_WAIT_IF, S_FLUSH} state_e;

    state_e           state_q, state_d;
    excp_t            excp_q, excp_d;
    logic             flush_q, flush_d;
    logic [31:0]      new_pc_q, new_pc_d;
    logic [CNT_W-1:0] sc_q, sc_d;
    logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
    logic             timeout_q, timeout_d;
    logic [5:0]       enc_stall;

    pipe_stall_enc u_enc (
        .req_if_i  (stallreq_if),
        .req_id_i  (stallreq_id),
        .req_ex_i  (stallreq_ex),
        .req_mem_i (stallreq_mem),
        .stall_o   (enc_stall)
    );

    always_comb begin
        state_d = state_q;
        excp_d  = excp_q;
        stall   = STALL_NONE;
        unique case (state_q)
            S_RUN: begin
                stall = enc_stall;
                if (excp_valid) begin
                    stall   = STALL_ALL;
                    excp_d  = '{code: excp_type, epc: cp0_epc};
                    state_d = stallreq_if ? S_WAIT_IF : S_FLUSH;
                end
            end
            S_WAIT_IF: begin
                stall = STALL_ALL;
                if (!stallreq_if) state_d = S_FLUSH;
            end
            S_FLUSH: begin
                stall   = STALL_NONE;
                state_d = S_RUN;
            end
            default: state_d = S_RUN;
        endcase
        // Nothing is frozen while reset holds; requests only count once it drops.
        if (rst) stall = STALL_NONE;

        // Registered flush/new_pc line up with the cycle the FSM sits in FLUSH.
        flush_d  = (state_d == S_FLUSH);
        new_pc_d = ZERO_WORD;
        if (flush_d) new_pc_d = (excp_d.code == EXC_ERET) ? excp_d.epc : EXC_VECTOR;

        sc_d = sc_q;
        if (stall[0] == STOP && sc_q != {CNT_W{1'b1}}) sc_d = sc_q + 1'b1;

        to_cnt_d = '0;
        if (state_q == S_RUN && stall != STALL_NONE)
            to_cnt_d = (to_cnt_q == TO_W'(TIMEOUT_CYC)) ? to_cnt_q : to_cnt_q + 1'b1;
        timeout_d = timeout_q | (to_cnt_d == TO_W'(TIMEOUT_CYC));
    end

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            state_q   <= S_RUN;
            flush_q   <= 1'b0;
            new_pc_q  <= ZERO_WORD;
            sc_q      <= '0;
            to_cnt_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            flush_q   <= flush_d;
            new_pc_q  <= new_pc_d;
            sc_q      <= sc_d;
            to_cnt_q  <= to_cnt_d;
            timeout_q <= timeout_d;
        end
    end

    // Captured exception record is pure data and needs no reset.
    always_ff @(posedge clk) begin
        excp_q <= excp_d;
    end

    assign flush         = flush_q;
    assign new_pc        = new_pc_q;
    assign stall_cycles  = sc_q;
    assign stall_timeout = timeout_q;

endmodule
